clint_trap_ctrl: RTL and testbench
==================================

Name: clint_trap_ctrl

Overview:
- Core-local trap sequencer. Sits beside the CSR register file and drives its clint write/read port.
- On ecall, ebreak, mret, or a pending timer/external interrupt, it stalls the pipeline, performs the machine-mode CSR updates one write per cycle, then redirects the PC to mtvec or mepc.
- Consumes the CSR file's mtvec, mepc, mstatus and global interrupt enable outputs.

Parameters:
- CAUSE_ECALL, 32'h0000000B, mcause value for ecall.
- CAUSE_EBREAK, 32'h00000003, mcause value for ebreak.
- CAUSE_TIMER, 32'h80000007, mcause value for timer interrupt.
- CAUSE_EXT, 32'h8000000B, mcause value for external interrupt.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- ecall_i  in  1  ecall decoded in id, one-cycle qualifier
- ebreak_i  in  1  ebreak decoded in id
- mret_i  in  1  mret decoded in id
- inst_addr_i  in  32  PC of instruction in id
- jump_flag_i  in  1  ex is redirecting this cycle
- jump_addr_i  in  32  ex redirect target
- tmr_int_i  in  1  timer interrupt request (level or pulse)
- ext_int_i  in  1  external interrupt request (level or pulse)
- wb_we_i  in  1  wb is writing the CSR file this cycle
- global_int_en_i  in  1  mstatus.MIE from CSR file
- csr_mtvec_i  in  32  mtvec
- csr_mepc_i  in  32  mepc
- csr_mstatus_i  in  32  mstatus
- we_o  out  1  CSR write enable (clint port)
- waddr_o  out  32  CSR write address; bits [11:0] significant, upper bits zero
- raddr_o  out  32  CSR read address; constant 0
- wdata_o  out  32  CSR write data
- hold_flag_o  out  1  stall pc/if/id while sequencing
- int_assert_o  out  1  one-cycle PC redirect strobe
- int_addr_o  out  32  redirect target

Behaviour:
- Reset (rst=0 at a clk edge):
  - State returns to IDLE.
  - Both pending latches clear.
  - All outputs are 0.
  - Applies mid-sequence: any partial CSR update is abandoned.
- Pending latches:
  - tmr_pend and ext_pend are set on any cycle their input is high.
  - The latch for the taken source clears when its trap is accepted.
  - Latches persist while global_int_en_i=0.
- Accept rule, evaluated in IDLE only, in priority order:
  - ecall_i, then ebreak_i, then mret_i (synchronous events).
  - ext_pend, then tmr_pend. Asynchronous events are taken only when global_int_en_i=1.
- On accept of a synchronous trap:
  - saved_pc = inst_addr_i.
  - saved_cause = CAUSE_ECALL or CAUSE_EBREAK.
- On accept of an asynchronous trap:
  - saved_pc = jump_addr_i if jump_flag_i=1, else inst_addr_i.
  - saved_cause = CAUSE_EXT or CAUSE_TIMER.
- hold_flag_o = 1 in every non-IDLE state. It is also 1 combinationally in the accept cycle.
- State machine for traps: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTATUS -> JUMP -> IDLE.
  - W_MEPC: we_o=1, waddr_o=0x341, wdata_o=saved_pc.
  - W_MCAUSE: we_o=1, waddr_o=0x342, wdata_o=saved_cause.
  - W_MSTATUS: we_o=1, waddr_o=0x300, wdata_o = csr_mstatus_i with bit7 (MPIE) = csr_mstatus_i[3] and bit3 (MIE) = 0.
  - JUMP: int_assert_o=1, int_addr_o = {csr_mtvec_i[31:2], 2'b00}.
- State machine for mret: IDLE -> W_MRET -> JUMP_RET -> IDLE.
  - W_MRET: we_o=1, waddr_o=0x300, wdata_o = csr_mstatus_i with bit3 = csr_mstatus_i[7] and bit7 = 1.
  - JUMP_RET: int_assert_o=1, int_addr_o=csr_mepc_i.
- Write collision:
  - The CSR file gives wb priority, so if wb_we_i=1 in any write state, the block holds that state with outputs unchanged.
  - It retries the same write next cycle and advances only on a cycle with wb_we_i=0.
- Outside write states: we_o=0, waddr_o=0, wdata_o=0.
- Outside JUMP/JUMP_RET: int_assert_o=0, int_addr_o=0.
- Latency, no collisions:
  - trap accept to int_assert_o = 4 cycles.
  - mret accept to int_assert_o = 2 cycles.
- Requests arriving while non-IDLE:
  - Synchronous requests are ignored, since id is held and will re-present them.
  - Asynchronous requests are latched.
- Back-to-back: a pending interrupt can be accepted on the first IDLE cycle after JUMP, subject to MIE. MIE is 0 after a trap, so nesting occurs only after mret or a software re-enable.

Test Plan:
- ecall_i=1, inst_addr_i=0x100, mtvec=0x205, mstatus=0x8, no wb writes -> three writes in order: 0x341<-0x100, 0x342<-0xB, 0x300<-0x80. int_assert_o at cycle 4 with int_addr_o=0x204. hold_flag_o high throughout.
- mret_i=1, mstatus=0x80, mepc=0x104 -> write 0x300<-0x88; int_assert_o next cycle with addr 0x104.
- tmr_int_i pulsed while global_int_en_i=0, then global_int_en_i=1 with inst_addr_i=0x300, jump_flag_i=1, jump_addr_i=0x400 -> mepc<-0x400, mcause<-0x80000007; tmr_pend cleared.
- ext_int_i and tmr_int_i asserted together with ecall_i=1 -> ecall taken first (mcause 0xB); both pending latches remain set.
- wb_we_i=1 for 2 cycles during W_MCAUSE -> mcause write repeated for 3 cycles; jump delayed by 2 cycles; values unchanged.
- rst=0 asserted during W_MCAUSE -> next cycle all outputs 0, state IDLE, pending cleared; after release, no spurious int_assert_o.

Source files
------------

// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl: core-local trap sequencer.
// Stalls the pipeline on ecall/ebreak/mret or an enabled pending interrupt.
// Writes mepc, mcause and mstatus (or mstatus only for mret) through the
// CSR file's clint port, one write per cycle, then redirects the PC.
// Ports:
//   clk, rst (sync, active-low)
//   ecall_i/ebreak_i/mret_i, inst_addr_i     - id-stage trap requests and PC
//   jump_flag_i/jump_addr_i                  - ex-stage redirect
//   tmr_int_i/ext_int_i                      - interrupt requests (latched)
//   wb_we_i                                  - wb owns the CSR write port
//   global_int_en_i, csr_mtvec_i/mepc_i/mstatus_i - CSR file outputs
//   we_o/waddr_o/raddr_o/wdata_o             - CSR write/read port
//   hold_flag_o, int_assert_o, int_addr_o    - stall and PC redirect
module clint_trap_ctrl #(
    parameter logic [31:0] CAUSE_ECALL  = 32'h0000000B,
    parameter logic [31:0] CAUSE_EBREAK = 32'h00000003,
    parameter logic [31:0] CAUSE_TIMER  = 32'h80000007,
    parameter logic [31:0] CAUSE_EXT    = 32'h8000000B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        tmr_int_i,
    input  logic        ext_int_i,
    input  logic        wb_we_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] raddr_o,
    output logic [31:0] wdata_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_JUMP,
        S_W_MRET,
        S_JUMP_RET
    } state_t;

    localparam logic [31:0] ADDR_MSTATUS = 32'h00000300;
    localparam logic [31:0] ADDR_MEPC    = 32'h00000341;
    localparam logic [31:0] ADDR_MCAUSE  = 32'h00000342;

    state_t      state;
    logic        tmr_pend;
    logic        ext_pend;
    logic [31:0] saved_pc;
    logic [31:0] saved_cause;

    logic        idle;
    logic        sync_req;
    logic        take_ext;
    logic        take_tmr;
    logic        accept;
    logic [31:0] async_pc;

    // mtvec mode bits are ignored: only direct mode is supported.
    logic        unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_i[1:0];

    always_comb begin
        idle     = (state == S_IDLE) && rst;
        sync_req = ecall_i | ebreak_i | mret_i;
        take_ext = idle && !sync_req && global_int_en_i && ext_pend;
        take_tmr = idle && !sync_req && global_int_en_i && !ext_pend && tmr_pend;
        accept   = idle && (sync_req || take_ext || take_tmr);
        // An interrupt must resume at the instruction ex is jumping to.
        async_pc = jump_flag_i ? jump_addr_i : inst_addr_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            tmr_pend    <= 1'b0;
            ext_pend    <= 1'b0;
            saved_pc    <= '0;
            saved_cause <= '0;
        end else begin
            // A request high in the accept cycle re-arms the latch.
            tmr_pend <= tmr_int_i | (tmr_pend & ~take_tmr);
            ext_pend <= ext_int_i | (ext_pend & ~take_ext);
            case (state)
                S_IDLE: begin
                    if (ecall_i) begin
                        saved_pc    <= inst_addr_i;
                        saved_cause <= CAUSE_ECALL;
                        state       <= S_W_MEPC;
                    end else if (ebreak_i) begin
                        saved_pc    <= inst_addr_i;
                        saved_cause <= CAUSE_EBREAK;
                        state       <= S_W_MEPC;
                    end else if (mret_i) begin
                        state       <= S_W_MRET;
                    end else if (take_ext) begin
                        saved_pc    <= async_pc;
                        saved_cause <= CAUSE_EXT;
                        state       <= S_W_MEPC;
                    end else if (take_tmr) begin
                        saved_pc    <= async_pc;
                        saved_cause <= CAUSE_TIMER;
                        state       <= S_W_MEPC;
                    end
                end
                // Write states retry while wb owns the CSR write port.
                S_W_MEPC:    if (!wb_we_i) state <= S_W_MCAUSE;
                S_W_MCAUSE:  if (!wb_we_i) state <= S_W_MSTATUS;
                S_W_MSTATUS: if (!wb_we_i) state <= S_JUMP;
                S_W_MRET:    if (!wb_we_i) state <= S_JUMP_RET;
                S_JUMP:      state <= S_IDLE;
                S_JUMP_RET:  state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        we_o         = 1'b0;
        waddr_o      = '0;
        raddr_o      = '0;
        wdata_o      = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        hold_flag_o  = ((state != S_IDLE) && rst) || accept;
        if (rst) begin
            case (state)
                S_W_MEPC: begin
                    we_o    = 1'b1;
                    waddr_o = ADDR_MEPC;
                    wdata_o = saved_pc;
                end
                S_W_MCAUSE: begin
                    we_o    = 1'b1;
                    waddr_o = ADDR_MCAUSE;
                    wdata_o = saved_cause;
                end
                S_W_MSTATUS: begin
                    // MPIE <= MIE, MIE <= 0
                    we_o    = 1'b1;
                    waddr_o = ADDR_MSTATUS;
                    wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                               csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
                end
                S_W_MRET: begin
                    // MIE <= MPIE, MPIE <= 1
                    we_o    = 1'b1;
                    waddr_o = ADDR_MSTATUS;
                    wdata_o = {csr_mstatus_i[31:8], 1'b1,
                               csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
                end
                S_JUMP: begin
                    int_assert_o = 1'b1;
                    int_addr_o   = {csr_mtvec_i[31:2], 2'b00};
                end
                S_JUMP_RET: begin
                    int_assert_o = 1'b1;
                    int_addr_o   = csr_mepc_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Directed bench for clint_trap_ctrl: trap/mret sequences, interrupt
// latching and priority, wb write collision, and mid-sequence reset.
module tb_clint_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_i, ebreak_i, mret_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        tmr_int_i, ext_int_i, wb_we_i, global_int_en_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        we_o;
    logic [31:0] waddr_o, raddr_o, wdata_o;
    logic        hold_flag_o, int_assert_o;
    logic [31:0] int_addr_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    clint_trap_ctrl #(
        .CAUSE_ECALL (32'h0000000B),
        .CAUSE_EBREAK(32'h00000003),
        .CAUSE_TIMER (32'h80000007),
        .CAUSE_EXT   (32'h8000000B)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ecall_i        (ecall_i),
        .ebreak_i       (ebreak_i),
        .mret_i         (mret_i),
        .inst_addr_i    (inst_addr_i),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .tmr_int_i      (tmr_int_i),
        .ext_int_i      (ext_int_i),
        .wb_we_i        (wb_we_i),
        .global_int_en_i(global_int_en_i),
        .csr_mtvec_i    (csr_mtvec_i),
        .csr_mepc_i     (csr_mepc_i),
        .csr_mstatus_i  (csr_mstatus_i),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .raddr_o        (raddr_o),
        .wdata_o        (wdata_o),
        .hold_flag_o    (hold_flag_o),
        .int_assert_o   (int_assert_o),
        .int_addr_o     (int_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full output vector check; raddr_o is always 0.
    task automatic chk_out(input string tag, input logic we, input logic [31:0] wa,
                           input logic [31:0] wd, input logic hold, input logic ia,
                           input logic [31:0] iaddr);
        chk({tag, ".we"},    {31'd0, we_o},         {31'd0, we});
        chk({tag, ".waddr"}, waddr_o,               wa);
        chk({tag, ".wdata"}, wdata_o,               wd);
        chk({tag, ".hold"},  {31'd0, hold_flag_o},  {31'd0, hold});
        chk({tag, ".ia"},    {31'd0, int_assert_o}, {31'd0, ia});
        chk({tag, ".iaddr"}, int_addr_o,            iaddr);
        chk({tag, ".raddr"}, raddr_o,               32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ecall_i = 0; ebreak_i = 0; mret_i = 0;
        inst_addr_i = '0; jump_flag_i = 0; jump_addr_i = '0;
        tmr_int_i = 0; ext_int_i = 0; wb_we_i = 0; global_int_en_i = 0;
        csr_mtvec_i = 32'h205; csr_mepc_i = '0; csr_mstatus_i = 32'h8;
        tick(); tick();
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk_out("idle", 0, 0, 0, 0, 0, 0);

        // ecall trap sequence
        ecall_i = 1; inst_addr_i = 32'h100;
        #1 chk("ecall.accept_hold", {31'd0, hold_flag_o}, 32'd1);
        tick(); ecall_i = 0;
        chk_out("ecall.mepc",    1, 32'h341, 32'h100, 1, 0, 0);
        tick(); chk_out("ecall.mcause",  1, 32'h342, 32'h0B,  1, 0, 0);
        tick(); chk_out("ecall.mstatus", 1, 32'h300, 32'h80,  1, 0, 0);
        tick(); chk_out("ecall.jump",    0, 0, 0, 1, 1, 32'h204);
        tick(); chk_out("ecall.idle",    0, 0, 0, 0, 0, 0);

        // mret
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; mret_i = 1;
        tick(); mret_i = 0;
        chk_out("mret.write", 1, 32'h300, 32'h88, 1, 0, 0);
        tick(); chk_out("mret.jump", 0, 0, 0, 1, 1, 32'h104);
        tick(); chk_out("mret.idle", 0, 0, 0, 0, 0, 0);

        // timer pulse held off by MIE=0, then taken with ex redirect
        tmr_int_i = 1;
        tick(); tmr_int_i = 0;
        tick(); chk_out("tmr.masked", 0, 0, 0, 0, 0, 0);
        global_int_en_i = 1; inst_addr_i = 32'h300;
        jump_flag_i = 1; jump_addr_i = 32'h400; csr_mstatus_i = 32'h88;
        #1 chk("tmr.accept_hold", {31'd0, hold_flag_o}, 32'd1);
        tick(); jump_flag_i = 0;
        chk_out("tmr.mepc",    1, 32'h341, 32'h400,      1, 0, 0);
        tick(); chk_out("tmr.mcause",  1, 32'h342, 32'h80000007, 1, 0, 0);
        tick(); chk_out("tmr.mstatus", 1, 32'h300, 32'h80,       1, 0, 0);
        tick(); chk_out("tmr.jump",    0, 0, 0, 1, 1, 32'h204);
        tick(); chk_out("tmr.cleared1", 0, 0, 0, 0, 0, 0);
        tick(); chk_out("tmr.cleared2", 0, 0, 0, 0, 0, 0);

        // ecall beats simultaneous interrupts; both latches survive
        global_int_en_i = 0;
        ecall_i = 1; ext_int_i = 1; tmr_int_i = 1; inst_addr_i = 32'h500;
        tick(); ecall_i = 0; ext_int_i = 0; tmr_int_i = 0;
        chk_out("prio.mepc", 1, 32'h341, 32'h500, 1, 0, 0);
        tick(); chk_out("prio.mcause", 1, 32'h342, 32'h0B, 1, 0, 0);
        tick(); tick(); chk_out("prio.jump", 0, 0, 0, 1, 1, 32'h204);
        tick(); chk_out("prio.idle_masked", 0, 0, 0, 0, 0, 0);
        global_int_en_i = 1; inst_addr_i = 32'h600;
        #1 chk("prio.ext_hold", {31'd0, hold_flag_o}, 32'd1);
        tick(); chk_out("ext.mepc", 1, 32'h341, 32'h600, 1, 0, 0);
        tick(); chk_out("ext.mcause", 1, 32'h342, 32'h8000000B, 1, 0, 0);
        tick(); tick(); chk_out("ext.jump", 0, 0, 0, 1, 1, 32'h204);
        tick(); chk("tmr2.accept_hold", {31'd0, hold_flag_o}, 32'd1);
        tick(); chk_out("tmr2.mepc", 1, 32'h341, 32'h600, 1, 0, 0);
        tick(); chk_out("tmr2.mcause", 1, 32'h342, 32'h80000007, 1, 0, 0);
        tick(); tick(); chk_out("tmr2.jump", 0, 0, 0, 1, 1, 32'h204);
        tick(); chk_out("tmr2.idle", 0, 0, 0, 0, 0, 0);
        global_int_en_i = 0;

        // wb collision during W_MCAUSE
        ecall_i = 1; inst_addr_i = 32'h700;
        tick(); ecall_i = 0;
        chk_out("coll.mepc", 1, 32'h341, 32'h700, 1, 0, 0);
        tick(); chk_out("coll.mcause0", 1, 32'h342, 32'h0B, 1, 0, 0);
        wb_we_i = 1;
        tick(); chk_out("coll.mcause1", 1, 32'h342, 32'h0B, 1, 0, 0);
        tick(); chk_out("coll.mcause2", 1, 32'h342, 32'h0B, 1, 0, 0);
        wb_we_i = 0;
        tick(); chk_out("coll.mstatus", 1, 32'h300, 32'h80, 1, 0, 0);
        tick(); chk_out("coll.jump", 0, 0, 0, 1, 1, 32'h204);
        tick(); chk_out("coll.idle", 0, 0, 0, 0, 0, 0);

        // reset mid-sequence abandons the update and clears pending
        ecall_i = 1; inst_addr_i = 32'h800;
        tick(); ecall_i = 0; tmr_int_i = 1;
        chk_out("rst.mepc", 1, 32'h341, 32'h800, 1, 0, 0);
        tick(); tmr_int_i = 0;
        chk_out("rst.mcause", 1, 32'h342, 32'h0B, 1, 0, 0);
        rst = 0;
        tick(); chk_out("rst.asserted", 0, 0, 0, 0, 0, 0);
        rst = 1; global_int_en_i = 1;
        #1 chk("rst.no_pend_hold", {31'd0, hold_flag_o}, 32'd0);
        tick(); chk_out("rst.after1", 0, 0, 0, 0, 0, 0);
        tick(); chk_out("rst.after2", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
